// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard controller: stalls PC/IF-ID and bubbles ID/EX behind a load,
// waits out a busy data memory, then pulses the WB-to-EX forward selects once.
module load_use_stall_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  mem_busy,
    input  logic                  flush,
    output logic                  stall,
    output logic                  bubble_enable,
    output logic                  forward_from_wb_stage_to_rs1,
    output logic                  forward_from_wb_stage_to_rs2,
    output logic [CNT_W-1:0]      hazard_count
);

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        MEM_WAIT,
        FWD
    } state_t;

    // Countdown holds STALL_CYCLES-1, so four bits cover the legal 1..15 range.
    localparam logic [3:0] CNT_INIT = 4'(STALL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             m1_q, m1_d;
    logic             m2_q, m2_d;
    logic [CNT_W-1:0] hazard_count_q, hazard_count_d;

    logic hit1, hit2, hazard;

    always_comb begin
        hit1   = id_rs1_used & (id_rs1 == ex_rd);
        hit2   = id_rs2_used & (id_rs2 == ex_rd);
        hazard = ex_is_load & (ex_rd != '0) & (hit1 | hit2);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            m1_q           <= 1'b0;
            m2_q           <= 1'b0;
            hazard_count_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            m1_q           <= m1_d;
            m2_q           <= m2_d;
            hazard_count_q <= hazard_count_d;
        end
    end

    // NOTE: every signal gets a default first, which keeps this block free of
    // inferred latches even on paths that do not assign it.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        m1_d           = m1_q;
        m2_d           = m2_q;
        hazard_count_d = hazard_count_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            m1_d    = 1'b0;
            m2_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, FWD: begin
                    // FWD re-arms directly so back-to-back loads skip IDLE.
                    state_d = IDLE;
                    if (hazard) begin
                        state_d = STALL;
                        cnt_d   = CNT_INIT;
                        m1_d    = hit1;
                        m2_d    = hit2;
                        if (hazard_count_q != '1) begin
                            hazard_count_d = hazard_count_q + 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (mem_busy) begin
                        state_d = MEM_WAIT;
                    end else begin
                        state_d = FWD;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state_d = FWD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stall                        = 1'b0;
        bubble_enable                = 1'b0;
        forward_from_wb_stage_to_rs1 = 1'b0;
        forward_from_wb_stage_to_rs2 = 1'b0;
        unique case (state_q)
            STALL, MEM_WAIT: begin
                stall         = 1'b1;
                bubble_enable = 1'b1;
            end
            FWD: begin
                forward_from_wb_stage_to_rs1 = m1_q;
                forward_from_wb_stage_to_rs2 = m2_q;
            end
            default: ;
        endcase
    end

    assign hazard_count = hazard_count_q;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Bench for load_use_stall_ctrl: two configurations driven in parallel and
// compared every cycle against a cycle-level behavioural model.
module tb_load_use_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_is_load;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used, mem_busy, flush;

    logic        a_stall, a_bubble, a_f1, a_f2;
    logic [15:0] a_cnt;
    logic        b_stall, b_bubble, b_f1, b_f2;
    logic [1:0]  b_cnt;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state per configuration: 0 = (STALL_CYCLES=1, CNT_W=16), 1 = (3, 2).
    int stall_len [2] = '{1, 3};
    int cnt_max   [2] = '{65535, 3};
    bit stalling  [2];
    int remaining [2];
    bit lat1 [2], lat2 [2];
    bit fwd1 [2], fwd2 [2];
    int count [2];

    always #5 clk = ~clk;

    load_use_stall_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .mem_busy(mem_busy), .flush(flush),
        .stall(a_stall), .bubble_enable(a_bubble),
        .forward_from_wb_stage_to_rs1(a_f1), .forward_from_wb_stage_to_rs2(a_f2),
        .hazard_count(a_cnt)
    );

    load_use_stall_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .mem_busy(mem_busy), .flush(flush),
        .stall(b_stall), .bubble_enable(b_bubble),
        .forward_from_wb_stage_to_rs1(b_f1), .forward_from_wb_stage_to_rs2(b_f2),
        .hazard_count(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs applied for it.
    task automatic model_edge();
        bit h1, h2, haz;
        h1  = id_rs1_used && (id_rs1 == ex_rd);
        h2  = id_rs2_used && (id_rs2 == ex_rd);
        haz = ex_is_load && (ex_rd != 0) && (h1 || h2);
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                stalling[i] = 0; fwd1[i] = 0; fwd2[i] = 0;
                lat1[i] = 0; lat2[i] = 0; count[i] = 0;
            end else if (flush) begin
                stalling[i] = 0; fwd1[i] = 0; fwd2[i] = 0;
                lat1[i] = 0; lat2[i] = 0;
            end else if (stalling[i]) begin
                fwd1[i] = 0; fwd2[i] = 0;
                if (remaining[i] > 1) remaining[i]--;
                else if (!mem_busy) begin
                    stalling[i] = 0;
                    fwd1[i] = lat1[i];
                    fwd2[i] = lat2[i];
                end
            end else begin
                fwd1[i] = 0; fwd2[i] = 0;
                if (haz) begin
                    stalling[i]  = 1;
                    remaining[i] = stall_len[i];
                    lat1[i] = h1;
                    lat2[i] = h2;
                    count[i] = (count[i] + 1 > cnt_max[i]) ? cnt_max[i] : count[i] + 1;
                end
            end
        end
    endtask

    task automatic step(input bit rst_v, input bit ld, input int rd, input int rs1,
                        input int rs2, input bit u1, input bit u2, input bit busy,
                        input bit fl);
        reset       = rst_v;
        ex_is_load  = ld;
        ex_rd       = 5'(rd);
        id_rs1      = 5'(rs1);
        id_rs2      = 5'(rs2);
        id_rs1_used = u1;
        id_rs2_used = u2;
        mem_busy    = busy;
        flush       = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("a.stall",  32'(a_stall),  32'(stalling[0]));
        check("a.bubble", 32'(a_bubble), 32'(stalling[0]));
        check("a.fwd1",   32'(a_f1),     32'(fwd1[0]));
        check("a.fwd2",   32'(a_f2),     32'(fwd2[0]));
        check("a.count",  32'(a_cnt),    32'(count[0]));
        check("b.stall",  32'(b_stall),  32'(stalling[1]));
        check("b.bubble", 32'(b_bubble), 32'(stalling[1]));
        check("b.fwd1",   32'(b_f1),     32'(fwd1[1]));
        check("b.fwd2",   32'(b_f2),     32'(fwd2[1]));
        check("b.count",  32'(b_cnt),    32'(count[1]));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held for two edges with a live hazard on the inputs.
        step(0, 1, 5, 5, 7, 1, 1, 0, 0);
        step(0, 1, 5, 5, 7, 1, 1, 0, 0);
        idle(2);

        // Single rs1 hazard, memory ready.
        step(1, 1, 5, 5, 7, 1, 1, 0, 0);
        idle(6);

        // x0 destination and an unused matching operand never stall.
        step(1, 1, 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, 9, 3, 9, 1, 0, 0, 0);
        step(1, 1, 9, 3, 9, 1, 0, 1, 0);
        idle(2);

        // Both operands hit, memory busy for a while after the countdown.
        step(1, 1, 12, 12, 12, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);

        // Flush on the second stall cycle, then hazard and flush together.
        step(1, 1, 4, 4, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        step(1, 1, 4, 4, 0, 1, 0, 0, 1);
        idle(3);

        // Hazard held continuously: back-to-back re-entry and counter saturation.
        for (int k = 0; k < 20; k++) step(1, 1, 6, 1, 6, 0, 1, 0, 0);
        idle(6);

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/load_use_stall_ctrl.md
Name: load_use_stall_ctrl

Overview:
Parametrised load-use hazard controller for the RV32IM pipeline. It detects an ID-stage instruction that reads the destination of a load in EX, and holds PC and IF/ID for a configurable number of cycles while inserting bubbles into ID/EX. It extends the stall while the data memory reports busy, then raises WB-to-EX forward selects for exactly one cycle. It also keeps a saturating hazard counter for performance analysis.

Parameters:
REG_ADDR_W, 5, register address width
STALL_CYCLES, 1, minimum bubble cycles per hazard (legal 1..15)
CNT_W, 16, width of hazard_count

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset)
ex_is_load  in  1  instruction in EX is a load
ex_rd  in  REG_ADDR_W  destination register of EX instruction
id_rs1  in  REG_ADDR_W  rs1 of ID instruction
id_rs2  in  REG_ADDR_W  rs2 of ID instruction
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
mem_busy  in  1  data memory not ready (multi-cycle access)
flush  in  1  branch/jump flush; aborts any stall
stall  out  1  hold PC and IF/ID
bubble_enable  out  1  load NOP into ID/EX
forward_from_wb_stage_to_rs1  out  1  select WB data for rs1
forward_from_wb_stage_to_rs2  out  1  select WB data for rs2
hazard_count  out  CNT_W  number of hazards detected, saturating

Behaviour:
- Detection (combinational): hit1 = id_rs1_used & (id_rs1 == ex_rd); hit2 = id_rs2_used & (id_rs2 == ex_rd); hazard = ex_is_load & (ex_rd != 0) & (hit1 | hit2). x0 never causes a hazard.
- All outputs are registered Moore outputs decoded from the state. They change one clock after the edge at which their cause is sampled.
- Reset (reset==0 at an edge): state IDLE, cnt 0, latched m1/m2 0, hazard_count 0. All outputs 0 in the following cycle. Reset overrides every other input, including mid-stall.
- States: IDLE, STALL, MEM_WAIT, FWD.
- IDLE: if hazard, go to STALL, load cnt = STALL_CYCLES-1, latch m1=hit1 and m2=hit2, and increment hazard_count. Otherwise stay in IDLE.
- STALL: stall=1, bubble_enable=1. ID/EX/WB inputs are ignored.
  - If cnt != 0: decrement cnt and stay in STALL.
  - If cnt == 0 and mem_busy: go to MEM_WAIT.
  - If cnt == 0 and not mem_busy: go to FWD.
  - Stall duration is STALL_CYCLES cycles plus any mem_busy extension.
- MEM_WAIT: stall=1, bubble_enable=1. Stay while mem_busy; go to FWD on the first edge with mem_busy==0.
- FWD: stall=0, bubble_enable=0, forward_from_wb_stage_to_rs1=m1, forward_from_wb_stage_to_rs2=m2, for exactly one cycle.
  - Next state is IDLE, except when hazard is also present: then go directly to STALL with new latches and increment hazard_count (back-to-back loads).
- Forward outputs are 0 in every state except FWD.
- flush==1 at any edge: next state IDLE, latches cleared, hazard_count unchanged. flush has priority over hazard. Reset has priority over flush.
- hazard_count saturates at 2^CNT_W-1 and never wraps.
- m1 and m2 may both be 1 (for example add x5,x5,x5).

Test Plan:
- Reset: hold reset=0 for 2 edges with hazard inputs active -> all outputs 0 and hazard_count=0. Release; outputs stay 0 until the first hazard edge.
- STALL_CYCLES=1, ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1, id_rs2=7, mem_busy=0 -> stall=1 and bubble_enable=1 for 1 cycle; then fwd rs1=1, rs2=0 for 1 cycle; then all outputs 0; hazard_count=1.
- ex_rd=0 with id_rs1=0 used, or ex_rd=9 with id_rs2=9 but id_rs2_used=0 -> no stall ever, hazard_count stays 0.
- STALL_CYCLES=3 with a hazard on both operands (rs1=rs2=rd=12) and mem_busy=1 for 2 cycles after the countdown -> stall for 5 cycles, then both forwards=1 for 1 cycle.
- Hazard detected, then flush=1 on the second stall cycle -> stall and bubble drop next cycle, no forward pulse, hazard_count=1. Separately, hazard and flush in the same cycle -> no stall, count unchanged.
- Back-to-back: hazard present during the FWD cycle -> STALL re-entered with no IDLE cycle, hazard_count=2. CNT_W=2 with 5 hazards -> hazard_count=3.
